execute_stage: RTL

EXECUTE_STAGE -- requirements
Module: execute_stage

---
 rtl/execute_stage.sv | 132 +++++++++++++
 1 files changed

// File: rtl/execute_stage.sv
// Execute stage of a five-stage RISC-V pipeline: operand forwarding, ALU, branch
// resolution, and the EX/MEM pipeline register.
module execute_stage (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        RegWriteE,
   input  logic        MemWriteE,
   input  logic        JumpE,
   input  logic        BranchE,
   input  logic        ALUSrcE,
   input  logic [1:0]  ResultSrcE,
   input  logic [2:0]  ALUControlE,
   input  logic [31:0] RD1E,
   input  logic [31:0] RD2E,
   input  logic [31:0] PCE,
   input  logic [31:0] PC_plus4E,
   input  logic [31:0] ImmExtE,
   input  logic [4:0]  RdE,
   input  logic [1:0]  ForwardAE,
   input  logic [1:0]  ForwardBE,
   input  logic [31:0] ResultW,
   output logic        PCSrcE,
   output logic [31:0] PCTargetE,
   output logic        RegWriteM,
   output logic        MemWriteM,
   output logic [1:0]  ResultSrcM,
   output logic [31:0] ALUResultM,
   output logic [31:0] WriteDataM,
   output logic [4:0]  RdM,
   output logic [31:0] PC_plus4M
);

   logic [31:0] src_a;
   logic [31:0] src_b;
   logic [31:0] write_data_e;
   logic [31:0] alu_sum;
   logic [31:0] alu_diff;
   logic        alu_lt;
   logic [31:0] alu_result;
   logic        zero_e;

   logic        reg_write_d,   reg_write_q;
   logic        mem_write_d,   mem_write_q;
   logic [1:0]  result_src_d,  result_src_q;
   logic [31:0] alu_result_d,  alu_result_q;
   logic [31:0] write_data_d,  write_data_q;
   logic [4:0]  rd_d,          rd_q;
   logic [31:0] pc_plus4_d,    pc_plus4_q;

   // The M-stage forward source is the registered ALU result, so no loop forms.
   always_comb begin
      src_a = RD1E;
      case (ForwardAE)
         2'b01:   src_a = ResultW;
         2'b10:   src_a = alu_result_q;
         default: src_a = RD1E;
      endcase

      write_data_e = RD2E;
      case (ForwardBE)
         2'b01:   write_data_e = ResultW;
         2'b10:   write_data_e = alu_result_q;
         default: write_data_e = RD2E;
      endcase

      src_b = ALUSrcE ? ImmExtE : write_data_e;
   end

   // Signed less-than from operand signs, falling back to the difference sign.
   always_comb begin
      alu_sum  = src_a + src_b;
      alu_diff = src_a - src_b;
      alu_lt   = (src_a[31] != src_b[31]) ? src_a[31] : alu_diff[31];

      alu_result = alu_sum;
      case (ALUControlE)
         3'b000:  alu_result = alu_sum;
         3'b001:  alu_result = alu_diff;
         3'b010:  alu_result = src_a & src_b;
         3'b011:  alu_result = src_a | src_b;
         3'b100:  alu_result = src_a ^ src_b;
         3'b101:  alu_result = {31'b0, alu_lt};
         3'b110:  alu_result = src_a << src_b[4:0];
         3'b111:  alu_result = src_a >> src_b[4:0];
         default: alu_result = alu_sum;
      endcase

      zero_e = (alu_result == 32'b0);
   end

   assign PCTargetE = PCE + ImmExtE;
   assign PCSrcE    = (BranchE & zero_e) | JumpE;

   always_comb begin
      reg_write_d  = RegWriteE;
      mem_write_d  = MemWriteE;
      result_src_d = ResultSrcE;
      alu_result_d = alu_result;
      write_data_d = write_data_e;
      rd_d         = RdE;
      pc_plus4_d   = PC_plus4E;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reg_write_q  <= 1'b0;
         mem_write_q  <= 1'b0;
         result_src_q <= 2'b0;
         alu_result_q <= 32'b0;
         write_data_q <= 32'b0;
         rd_q         <= 5'b0;
         pc_plus4_q   <= 32'b0;
      end else begin
         reg_write_q  <= reg_write_d;
         mem_write_q  <= mem_write_d;
         result_src_q <= result_src_d;
         alu_result_q <= alu_result_d;
         write_data_q <= write_data_d;
         rd_q         <= rd_d;
         pc_plus4_q   <= pc_plus4_d;
      end
   end

   assign RegWriteM  = reg_write_q;
   assign MemWriteM  = mem_write_q;
   assign ResultSrcM = result_src_q;
   assign ALUResultM = alu_result_q;
   assign WriteDataM = write_data_q;
   assign RdM        = rd_q;
   assign PC_plus4M  = pc_plus4_q;

endmodule
